// File: rtl/marquee_scroller.sv
// marquee_scroller: scrolls a writable glyph buffer across a multiplexed active-low 7-segment display.
// Optional MARQUEE_BOUNCE_EN selects ping-pong scrolling instead of circular wrap.
`default_nettype none

module marquee_scroller #(
  parameter int NUM_DIGITS  = 4,
  parameter int MSG_LEN     = 8,
  parameter int SCROLL_DIV  = 10000000,
  parameter int REFRESH_DIV = 200000,
  localparam int PTR_W      = $clog2(MSG_LEN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  dir_toggle,
  input  logic                  pause,
  input  logic                  wr_en,
  input  logic [PTR_W-1:0]      wr_addr,
  input  logic [6:0]            wr_data,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  step
);

  localparam int SC_W  = $clog2(SCROLL_DIV);
  localparam int RF_W  = $clog2(REFRESH_DIV);
  localparam int SEL_W = $clog2(NUM_DIGITS);

  localparam logic       DIR_LEFT  = 1'b0;
  localparam logic       DIR_RIGHT = 1'b1;
  localparam logic [6:0] BLANK     = 7'h7F;

  logic [6:0]            msg_q [MSG_LEN];
  logic [6:0]            msg_d [MSG_LEN];
  logic [PTR_W-1:0]      head_q, head_d;
  logic                  dir_q, dir_d;
  logic [SC_W-1:0]       scroll_cnt_q, scroll_cnt_d;
  logic [RF_W-1:0]       ref_cnt_q, ref_cnt_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  logic                  wr_ok;
  logic                  scroll_tick;
  logic                  ref_tick;
  logic [PTR_W-1:0]      head_inc, head_dec;
  logic [PTR_W:0]        idx_sum;
  logic [PTR_W-1:0]      glyph_idx;
  logic [6:0]            glyph;
  logic [NUM_DIGITS-1:0] an_slot;

  // Message buffer write port
  assign wr_ok = wr_en && ({1'b0, wr_addr} < (PTR_W+1)'(MSG_LEN));

  always_comb begin
    for (int i = 0; i < MSG_LEN; i++) begin
      msg_d[i] = msg_q[i];
      if (wr_ok && (wr_addr == PTR_W'(i))) msg_d[i] = wr_data;
    end
  end

  // Scroll timing and head/direction update
  always_comb begin
    scroll_tick  = !pause && (scroll_cnt_q == SC_W'(SCROLL_DIV - 1));
    scroll_cnt_d = scroll_cnt_q;
    if (!pause) scroll_cnt_d = scroll_tick ? '0 : scroll_cnt_q + 1'b1;

    head_inc = (head_q == PTR_W'(MSG_LEN - 1)) ? '0 : head_q + 1'b1;
    head_dec = (head_q == '0) ? PTR_W'(MSG_LEN - 1) : head_q - 1'b1;

    head_d = head_q;
    dir_d  = dir_q ^ dir_toggle;
    if (scroll_tick) begin
`ifdef MARQUEE_BOUNCE_EN
      // Bounce assignments override dir_d, so a coincident toggle is dropped.
      if (dir_q == DIR_LEFT && head_q == PTR_W'(MSG_LEN - NUM_DIGITS)) begin
        head_d = head_dec;
        dir_d  = DIR_RIGHT;
      end else if (dir_q == DIR_RIGHT && head_q == '0) begin
        head_d = PTR_W'(1);
        dir_d  = DIR_LEFT;
      end else begin
        head_d = (dir_q == DIR_RIGHT) ? head_dec : head_inc;
      end
`else
      head_d = (dir_q == DIR_RIGHT) ? head_dec : head_inc;
`endif
    end
  end

  // Glyph for the slot being refreshed: buf[(head + sel) mod MSG_LEN]
  always_comb begin
    idx_sum   = {1'b0, head_q} + (PTR_W+1)'(sel_q);
    glyph_idx = (idx_sum >= (PTR_W+1)'(MSG_LEN))
              ? PTR_W'(idx_sum - (PTR_W+1)'(MSG_LEN))
              : idx_sum[PTR_W-1:0];
    glyph     = msg_q[glyph_idx];
  end

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_an
    assign an_slot[gi] = (sel_q != SEL_W'(NUM_DIGITS - 1 - gi));
  end

  // sel_q names the slot loaded on the next refresh tick, so the first scan starts at the leftmost digit.
  always_comb begin
    ref_tick  = (ref_cnt_q == RF_W'(REFRESH_DIV - 1));
    ref_cnt_d = ref_tick ? '0 : ref_cnt_q + 1'b1;
    sel_d     = sel_q;
    seg_d     = seg_q;
    an_d      = an_q;
    if (ref_tick) begin
      sel_d = (sel_q == SEL_W'(NUM_DIGITS - 1)) ? '0 : sel_q + 1'b1;
      seg_d = glyph;
      an_d  = an_slot;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MSG_LEN; i++) msg_q[i] <= BLANK;
      head_q       <= '0;
      dir_q        <= DIR_LEFT;
      scroll_cnt_q <= '0;
      ref_cnt_q    <= '0;
      sel_q        <= '0;
      seg_q        <= BLANK;
      an_q         <= '1;
    end else begin
      for (int i = 0; i < MSG_LEN; i++) msg_q[i] <= msg_d[i];
      head_q       <= head_d;
      dir_q        <= dir_d;
      scroll_cnt_q <= scroll_cnt_d;
      ref_cnt_q    <= ref_cnt_d;
      sel_q        <= sel_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
    end
  end

  assign seg  = seg_q;
  assign an   = an_q;
  assign dp   = 1'b1;
  assign step = scroll_tick;

endmodule

`default_nettype wire

// File: tb/tb_marquee_scroller.sv
// Directed bench for marquee_scroller (NUM_DIGITS=4, MSG_LEN=6, SCROLL_DIV=8, REFRESH_DIV=2).
// Build with MARQUEE_BOUNCE_EN defined to exercise ping-pong mode.
`timescale 1ns/1ps

module tb_marquee_scroller;
  localparam int ND = 4;
  localparam int ML = 6;
  localparam int SD = 8;
  localparam int RD = 2;
  localparam int PW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          dir_toggle;
  logic          pause;
  logic          wr_en;
  logic [PW-1:0] wr_addr;
  logic [6:0]    wr_data;
  logic [6:0]    seg;
  logic          dp;
  logic [ND-1:0] an;
  logic          step;

  int checks = 0;
  int errors = 0;

  logic [6:0] g       [ML];
  logic [6:0] exp_msg [ML];

  typedef struct {
    logic          wr_en;
    logic [PW-1:0] wr_addr;
    logic [6:0]    wr_data;
    logic [ND-1:0] exp_an;
    logic [6:0]    exp_seg;
  } vec_t;

  vec_t vecs [13];

  marquee_scroller #(
    .NUM_DIGITS (ND),
    .MSG_LEN    (ML),
    .SCROLL_DIV (SD),
    .REFRESH_DIV(RD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .dir_toggle(dir_toggle),
    .pause     (pause),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .seg       (seg),
    .dp        (dp),
    .an        (an),
    .step      (step)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Waits for a fresh scan, then checks all four slots against exp_msg rotated by h.
  task automatic check_scan(input string name, input int h);
    logic [ND-1:0] ea;
    repeat (8) @(negedge clk);
    for (int k = 0; k < 8 && an !== 4'b0111; k++) @(negedge clk);
    for (int i = 0; i < ND; i++) begin
      ea = ~(4'b1000 >> i);
      chk({name, "_an"}, 32'(an), 32'(ea));
      chk({name, "_seg"}, 32'(seg), 32'(exp_msg[(h + i) % ML]));
      repeat (2) @(negedge clk);
    end
    $display("scan %s head=%0d done", name, h);
  endtask

  // Runs exactly one scroll step from a zero scroll count, optionally toggling on the tick cycle.
  task automatic do_tick(input bit with_toggle);
    int n;
    n = 0;
    pause = 1'b0;
    while (step !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("tick_latency", 32'(n), 32'd7);
    if (with_toggle) dir_toggle = 1'b1;
    @(negedge clk);
    dir_toggle = 1'b0;
    pause      = 1'b1;
    chk("step_one_cycle", 32'(step), 32'd0);
    $display("tick toggle=%0d after %0d cycles", with_toggle, n);
  endtask

  initial begin
    int hi;
    bit found;
    rst_n      = 1'b0;
    dir_toggle = 1'b0;
    pause      = 1'b1;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;

    g[0] = 7'h01; g[1] = 7'h4F; g[2] = 7'h12;
    g[3] = 7'h06; g[4] = 7'h4C; g[5] = 7'h24;
    for (int i = 0; i < ML; i++) exp_msg[i] = 7'h7F;

    // Writes land one edge after each row; row 1 writes buf[0] on the same edge slot 0 reads it.
    vecs[0]  = '{1'b1, 3'd1, g[1], 4'b1111, 7'h7F};
    vecs[1]  = '{1'b1, 3'd0, g[0], 4'b1111, 7'h7F};
    vecs[2]  = '{1'b1, 3'd2, g[2], 4'b0111, 7'h7F};
    vecs[3]  = '{1'b1, 3'd3, g[3], 4'b0111, 7'h7F};
    vecs[4]  = '{1'b1, 3'd4, g[4], 4'b1011, g[1]};
    vecs[5]  = '{1'b1, 3'd5, g[5], 4'b1011, g[1]};
    vecs[6]  = '{1'b0, 3'd0, 7'h00, 4'b1101, g[2]};
    vecs[7]  = '{1'b0, 3'd0, 7'h00, 4'b1101, g[2]};
    vecs[8]  = '{1'b0, 3'd0, 7'h00, 4'b1110, g[3]};
    vecs[9]  = '{1'b0, 3'd0, 7'h00, 4'b1110, g[3]};
    vecs[10] = '{1'b0, 3'd0, 7'h00, 4'b0111, g[0]};
    vecs[11] = '{1'b0, 3'd0, 7'h00, 4'b0111, g[0]};
    vecs[12] = '{1'b0, 3'd0, 7'h00, 4'b1011, g[1]};

    repeat (2) @(negedge clk);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_dp", 32'(dp), 32'd1);
    chk("rst_step", 32'(step), 32'd0);
    rst_n = 1'b1;

    for (int r = 0; r < 13; r++) begin
      chk($sformatf("vec%0d_an", r), 32'(an), 32'(vecs[r].exp_an));
      chk($sformatf("vec%0d_seg", r), 32'(seg), 32'(vecs[r].exp_seg));
      chk($sformatf("vec%0d_dp", r), 32'(dp), 32'd1);
      chk($sformatf("vec%0d_step", r), 32'(step), 32'd0);
      $display("vec %0d an=%b seg=%h", r, an, seg);
      wr_en   = vecs[r].wr_en;
      wr_addr = vecs[r].wr_addr;
      wr_data = vecs[r].wr_data;
      @(negedge clk);
    end
    wr_en = 1'b0;
    for (int i = 0; i < ML; i++) exp_msg[i] = g[i];

`ifndef MARQUEE_BOUNCE_EN
    // First step arrives on the 8th counting cycle and lasts one cycle.
    pause = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("first_step_c%0d", k), 32'(step), (k == 7) ? 32'd1 : 32'd0);
    end
    pause = 1'b1;
    check_scan("t2_head1", 1);
    for (int t = 0; t < 5; t++) do_tick(1'b0);
    check_scan("t2_wrap", 0);

    // Direction reversal, then a toggle coincident with a tick.
    dir_toggle = 1'b1;
    @(negedge clk);
    dir_toggle = 1'b0;
    do_tick(1'b0);
    check_scan("t3_right_wrap", 5);
    do_tick(1'b1);
    check_scan("t3_old_dir", 4);
    do_tick(1'b0);
    check_scan("t3_new_dir", 5);

    // Pause with a partially counted scroll interval.
    pause = 1'b0;
    repeat (3) @(negedge clk);
    pause = 1'b1;
    hi = 0;
    repeat (40) begin
      @(negedge clk);
      if (step) hi++;
    end
    chk("pause_no_step", 32'(hi), 32'd0);
    wr_en   = 1'b1;
    wr_addr = 3'd5;
    wr_data = 7'h2A;
    exp_msg[5] = 7'h2A;
    @(negedge clk);
    wr_en = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      if (an === 4'b0111 && seg === 7'h2A) found = 1'b1;
      else @(negedge clk);
    end
    chk("pause_write_visible", 32'(found), 32'd1);
    pause = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("resume_step_c%0d", k), 32'(step), (k == 4) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    pause = 1'b1;
    check_scan("t4_after_resume", 0);
`else
    // Ping-pong: 0,1,2 -> bounce 1 (toggle dropped), 0 -> bounce 1, manual toggle, 0.
    do_tick(1'b0);
    check_scan("b_h1", 1);
    do_tick(1'b0);
    check_scan("b_h2", 2);
    do_tick(1'b1);
    check_scan("b_bounce_right", 1);
    do_tick(1'b0);
    check_scan("b_h0", 0);
    do_tick(1'b0);
    check_scan("b_bounce_left", 1);
    dir_toggle = 1'b1;
    @(negedge clk);
    dir_toggle = 1'b0;
    do_tick(1'b0);
    check_scan("b_manual_toggle", 0);
`endif

    // Out-of-range write is ignored.
    wr_en   = 1'b1;
    wr_addr = 3'd7;
    wr_data = 7'h00;
    @(negedge clk);
    wr_en = 1'b0;
    check_scan("t5_oob_write", 0);

    // Asynchronous reset mid-scan blanks outputs before any clock edge.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_seg", 32'(seg), 32'h7F);
    chk("async_rst_an", 32'(an), 32'hF);
    chk("async_rst_step", 32'(step), 32'd0);
    for (int i = 0; i < ML; i++) exp_msg[i] = 7'h7F;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_blank_an", 32'(an), 32'hF);
    chk("post_rst_blank_seg", 32'(seg), 32'h7F);
    @(negedge clk);
    chk("post_rst_first_an", 32'(an), 32'h7);
    chk("post_rst_first_seg", 32'(seg), 32'h7F);
    check_scan("t5_buffer_blank", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
